// File: rtl/servo_pwm_capture_if.sv
// Signal bundle between a servo PWM source and the pulse-width capture block.
// The capture block takes the slave view; the PWM source and result consumer take the master view.
interface servo_pwm_capture_if;
   logic        pwm_in;
   logic [15:0] width_us;
   logic [15:0] raw_us;
   logic        valid;
   logic        out_of_range;
   logic        signal_lost;

   modport master (
      output pwm_in,
      input  width_us,
      input  raw_us,
      input  valid,
      input  out_of_range,
      input  signal_lost
   );

   modport slave (
      input  pwm_in,
      output width_us,
      output raw_us,
      output valid,
      output out_of_range,
      output signal_lost
   );
endinterface

// File: rtl/servo_pwm_capture.sv
// Measures servo PWM high time in microseconds, rejecting glitches and stuck-high lines,
// and flags loss of signal when no pulse has been accepted for TIMEOUT_US.
module servo_pwm_capture #(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned MIN_US      = 1_000,
   parameter int unsigned MAX_US      = 2_000,
   parameter int unsigned GLITCH_US   = 500,
   parameter int unsigned MAXPULSE_US = 3_000,
   parameter int unsigned TIMEOUT_US  = 50_000
) (
   input logic                clk,
   input logic                rst,
   servo_pwm_capture_if.slave cap
);
   localparam int unsigned Div = CLK_HZ / 1_000_000;
   localparam int unsigned PsW = (Div > 1) ? $clog2(Div) : 1;
   localparam int unsigned ToW = $clog2(TIMEOUT_US + 1);

   localparam logic [PsW-1:0] PsLast    = PsW'(Div - 1);
   localparam logic [15:0]    MinW      = 16'(MIN_US);
   localparam logic [15:0]    MaxW      = 16'(MAX_US);
   localparam logic [15:0]    GlitchW   = 16'(GLITCH_US);
   localparam logic [15:0]    MaxPulseW = 16'(MAXPULSE_US);
   localparam logic [15:0]    ResetW    = 16'((MIN_US + MAX_US) / 2);
   localparam logic [ToW-1:0] ToLimit   = ToW'(TIMEOUT_US);

   typedef enum logic [1:0] {StWaitLow, StArmed, StHigh, StStuck} state_e;

   state_e         state_q, state_d;
   logic           s1_q, s2_q, s3_q;
   logic [1:0]     fill_q;
   logic [PsW-1:0] ps_q, ps_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [PsW-1:0] to_ps_q, to_ps_d;
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   logic [15:0]    width_q, width_d;
   logic [15:0]    raw_q, raw_d;
   logic           valid_q, valid_d;
   logic           oor_q, oor_d;
   logic           lost_q, lost_d;
   logic           rise, fall, us_tick, sync_ready;
   logic [15:0]    meas;

   assign rise       = s2_q & ~s3_q;
   assign fall       = ~s2_q & s3_q;
   assign sync_ready = (fill_q == 2'd2);
   assign us_tick    = (ps_q == PsLast);
   // Width including the current cycle's prescaler wrap, so N us of high yields exactly N.
   assign meas       = (us_tick && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      width_d = width_q;
      raw_d   = raw_q;
      oor_d   = oor_q;
      case (state_q)
         StWaitLow: begin
            // Synchronizer reset zeros are not a real observation of a low line.
            if (sync_ready && !s2_q) state_d = StArmed;
         end
         StArmed: begin
            if (rise) begin
               state_d = StHigh;
               ps_d    = '0;
               cnt_d   = '0;
            end
         end
         StHigh: begin
            ps_d  = us_tick ? '0 : ps_q + 1'b1;
            cnt_d = meas;
            if (meas > MaxPulseW) begin
               state_d = fall ? StArmed : StStuck;
            end else if (fall) begin
               state_d = StArmed;
               if (meas >= GlitchW) begin
                  valid_d = 1'b1;
                  raw_d   = meas;
                  oor_d   = (meas < MinW) || (meas > MaxW);
                  if (meas < MinW)      width_d = MinW;
                  else if (meas > MaxW) width_d = MaxW;
                  else                  width_d = meas;
               end
            end
         end
         StStuck: begin
            if (fall) state_d = StArmed;
         end
         default: state_d = StWaitLow;
      endcase
   end

   always_comb begin
      to_ps_d  = (to_ps_q == PsLast) ? '0 : to_ps_q + 1'b1;
      to_cnt_d = to_cnt_q;
      if (to_ps_q == PsLast && to_cnt_q != ToLimit) to_cnt_d = to_cnt_q + 1'b1;
      lost_d = lost_q | (to_cnt_d == ToLimit);
      if (valid_d) begin
         to_ps_d  = '0;
         to_cnt_d = '0;
         lost_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StWaitLow;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         fill_q   <= 2'd0;
         ps_q     <= '0;
         cnt_q    <= '0;
         to_ps_q  <= '0;
         to_cnt_q <= '0;
         width_q  <= ResetW;
         raw_q    <= '0;
         valid_q  <= 1'b0;
         oor_q    <= 1'b0;
         lost_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         s1_q     <= cap.pwm_in;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         if (!sync_ready) fill_q <= fill_q + 2'd1;
         ps_q     <= ps_d;
         cnt_q    <= cnt_d;
         to_ps_q  <= to_ps_d;
         to_cnt_q <= to_cnt_d;
         width_q  <= width_d;
         raw_q    <= raw_d;
         valid_q  <= valid_d;
         oor_q    <= oor_d;
         lost_q   <= lost_d;
      end
   end

   assign cap.width_us     = width_q;
   assign cap.raw_us       = raw_q;
   assign cap.valid        = valid_q;
   assign cap.out_of_range = oor_q;
   assign cap.signal_lost  = lost_q;
endmodule
